// File: rtl/rrocev2_rx_parser.sv
// RoCEv2 SEND_ONLY receive parser: buffers a 512-bit AXIS frame, validates ETH/IPv4/UDP/BTH
// headers and the expected PSN, and emits one good/dropped result pulse per frame.
module rrocev2_rx_parser #(
  parameter int          C_AXIS_DATA_WIDTH = 512,
  parameter int          PAYLOAD_LEN       = 56,
  parameter logic [47:0] LOCAL_MAC         = 48'h0,
  parameter logic [31:0] LOCAL_IP          = 32'h0,
  parameter logic [15:0] UDP_PORT          = 16'd4791,
  parameter logic [23:0] INIT_PSN          = 24'h0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic                           rx_valid,
  output logic [23:0]                    rx_dest_qp,
  output logic [23:0]                    rx_psn,
  output logic [PAYLOAD_LEN*8-1:0]       rx_payload,
  output logic                           rx_err_valid,
  output logic [2:0]                     rx_err_code,
  output logic [23:0]                    exp_psn,
  output logic [15:0]                    ok_cnt,
  output logic [15:0]                    err_cnt
);
  localparam int BEAT_BYTES = C_AXIS_DATA_WIDTH / 8;
  localparam int FRAME_LEN  = 58 + PAYLOAD_LEN;
  localparam int NBEATS     = (FRAME_LEN + BEAT_BYTES - 1) / BEAT_BYTES;
  localparam int BUF_W      = NBEATS * C_AXIS_DATA_WIDTH;
  localparam int BC_W       = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {IDLE, BODY, DROP, DONE} state_t;

  state_t                   state;
  logic [BC_W-1:0]          beat_cnt;
  logic [10:0]              byte_cnt;
  logic [BUF_W-1:0]         frame_buf;

  logic                     accept, over;
  logic [BC_W-1:0]          wr_idx;
  logic [BUF_W-1:0]         buf_nxt;
  logic [10:0]              byte_cnt_nxt;
  logic [47:0]              dst_mac;
  logic [31:0]              dst_ip;
  logic [15:0]              ethertype, total_len, udp_dport, udp_len, pkey;
  logic [23:0]              bth_qp, bth_psn;
  logic [19:0]              csum_acc;
  logic [16:0]              csum_f1;
  logic [15:0]              csum_f2;
  logic [2:0]               err_code;
  logic [PAYLOAD_LEN*8-1:0] payload_nxt;

  function automatic logic [10:0] popcount(input logic [BEAT_BYTES-1:0] k);
    logic [10:0] n = '0;
    for (int i = 0; i < BEAT_BYTES; i++) n += 11'(k[i]);
    return n;
  endfunction

  assign s_axis_tready = (state != DONE);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Checks run on the buffer as it will look after the current beat, so the
  // result is registered on the tlast edge and visible in the DONE cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    over         = (state == DROP) || (state == BODY && beat_cnt == BC_W'(NBEATS));
    wr_idx       = (state == IDLE) ? '0 : beat_cnt;
    buf_nxt      = frame_buf;
    if (accept && !over)
      buf_nxt[int'(wr_idx)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH] = s_axis_tdata;
    byte_cnt_nxt = ((state == IDLE) ? 11'd0 : byte_cnt) + popcount(s_axis_tkeep);

    dst_mac = '0;
    dst_ip  = '0;
    bth_qp  = '0;
    bth_psn = '0;
    for (int i = 0; i < 6; i++) dst_mac[8*(5-i) +: 8] = buf_nxt[8*i +: 8];
    for (int i = 0; i < 4; i++) dst_ip[8*(3-i) +: 8]  = buf_nxt[8*(30+i) +: 8];
    for (int i = 0; i < 3; i++) begin
      bth_qp[8*(2-i) +: 8]  = buf_nxt[8*(47+i) +: 8];
      bth_psn[8*(2-i) +: 8] = buf_nxt[8*(51+i) +: 8];
    end
    ethertype = {buf_nxt[8*12 +: 8], buf_nxt[8*13 +: 8]};
    total_len = {buf_nxt[8*16 +: 8], buf_nxt[8*17 +: 8]};
    udp_dport = {buf_nxt[8*36 +: 8], buf_nxt[8*37 +: 8]};
    udp_len   = {buf_nxt[8*38 +: 8], buf_nxt[8*39 +: 8]};
    pkey      = {buf_nxt[8*44 +: 8], buf_nxt[8*45 +: 8]};

    csum_acc = '0;
    for (int k = 0; k < 10; k++)
      csum_acc += {4'd0, buf_nxt[8*(14+2*k) +: 8], buf_nxt[8*(15+2*k) +: 8]};
    csum_f1 = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
    csum_f2 = csum_f1[15:0] + {15'd0, csum_f1[16]};

    if (dst_mac != LOCAL_MAC || ethertype != 16'h0800)
      err_code = 3'd1;
    else if (buf_nxt[8*14 +: 8] != 8'h45 || buf_nxt[8*23 +: 8] != 8'h11 ||
             dst_ip != LOCAL_IP || total_len != 16'(44 + PAYLOAD_LEN) || csum_f2 != 16'hFFFF)
      err_code = 3'd2;
    else if (udp_dport != UDP_PORT || udp_len != 16'(24 + PAYLOAD_LEN))
      err_code = 3'd3;
    else if (buf_nxt[8*42 +: 8] != 8'h04 || pkey != 16'hFFFF)
      err_code = 3'd4;
    else if (byte_cnt_nxt != 11'(FRAME_LEN) || over)
      err_code = 3'd5;
    else if (bth_psn != exp_psn)
      err_code = 3'd6;
    else
      err_code = 3'd0;

    // First payload byte lands in the MSBs, matching the generator's packing.
    payload_nxt = '0;
    for (int i = 0; i < PAYLOAD_LEN; i++)
      payload_nxt[8*(PAYLOAD_LEN-1-i) +: 8] = buf_nxt[8*(54+i) +: 8];
  end

  // NOTE: the frame buffer has no reset; every byte is rewritten before it is checked.
  always_ff @(posedge clk) begin
    if (accept) frame_buf <= buf_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      byte_cnt     <= '0;
      rx_valid     <= 1'b0;
      rx_err_valid <= 1'b0;
      rx_err_code  <= '0;
      rx_dest_qp   <= '0;
      rx_psn       <= '0;
      rx_payload   <= '0;
      exp_psn      <= INIT_PSN;
      ok_cnt       <= '0;
      err_cnt      <= '0;
    end else begin
      rx_valid     <= 1'b0;
      rx_err_valid <= 1'b0;
      if (state == DONE) state <= IDLE;
      if (accept) begin
        byte_cnt <= byte_cnt_nxt;
        if (!over) beat_cnt <= wr_idx + BC_W'(1);
        state <= over ? DROP : BODY;
        if (s_axis_tlast) begin
          state <= DONE;
          if (err_code == 3'd0) begin
            rx_valid    <= 1'b1;
            rx_err_code <= 3'd0;
            rx_dest_qp  <= bth_qp;
            rx_psn      <= bth_psn;
            rx_payload  <= payload_nxt;
            exp_psn     <= exp_psn + 24'd1;
            ok_cnt      <= ok_cnt + 16'd1;
          end else begin
            rx_err_valid <= 1'b1;
            rx_err_code  <= err_code;
            err_cnt      <= err_cnt + 16'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rrocev2_rx_parser.sv
// Directed bench for rrocev2_rx_parser: a table of frames with hand-derived results, plus
// hand-written sequences for PSN wrap and reset in the middle of a frame.
module tb_rrocev2_rx_parser;
  localparam int PL = 56;

  typedef logic [1535:0] frame_t;
  typedef enum {MOD_NONE, MOD_CSUM, MOD_ETYPE, MOD_UDP, MOD_BTH, MOD_EXTRA, MOD_TRUNC} mod_t;
  typedef struct {
    bit          do_rst;
    mod_t        m;
    logic [23:0] qp;
    logic [23:0] psn;
    bit          exp_ok;
    logic [2:0]  exp_code;
    logic [23:0] exp_psn;
    logic [15:0] exp_ok_cnt;
    logic [15:0] exp_err_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  tdata;
  logic [63:0]   tkeep;
  logic          tlast, tvalid_a, tvalid_b;

  logic          a_tready, a_rx_valid, a_rx_err_valid;
  logic [23:0]   a_rx_dest_qp, a_rx_psn, a_exp_psn;
  logic [PL*8-1:0] a_rx_payload;
  logic [2:0]    a_rx_err_code;
  logic [15:0]   a_ok_cnt, a_err_cnt;

  logic          b_tready, b_rx_valid, b_rx_err_valid;
  logic [23:0]   b_rx_dest_qp, b_rx_psn, b_exp_psn;
  logic [PL*8-1:0] b_rx_payload;
  logic [2:0]    b_rx_err_code;
  logic [15:0]   b_ok_cnt, b_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rrocev2_rx_parser u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid_a),
    .s_axis_tlast(tlast), .s_axis_tready(a_tready),
    .rx_valid(a_rx_valid), .rx_dest_qp(a_rx_dest_qp), .rx_psn(a_rx_psn),
    .rx_payload(a_rx_payload), .rx_err_valid(a_rx_err_valid), .rx_err_code(a_rx_err_code),
    .exp_psn(a_exp_psn), .ok_cnt(a_ok_cnt), .err_cnt(a_err_cnt)
  );

  rrocev2_rx_parser #(.INIT_PSN(24'hFFFFFF)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid_b),
    .s_axis_tlast(tlast), .s_axis_tready(b_tready),
    .rx_valid(b_rx_valid), .rx_dest_qp(b_rx_dest_qp), .rx_psn(b_rx_psn),
    .rx_payload(b_rx_payload), .rx_err_valid(b_rx_err_valid), .rx_err_code(b_rx_err_code),
    .exp_psn(b_exp_psn), .ok_cnt(b_ok_cnt), .err_cnt(b_err_cnt)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [PL*8-1:0] act, input logic [PL*8-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PL*8-1:0] exp_payload(input logic [23:0] psn);
    logic [PL*8-1:0] p = '0;
    for (int i = 0; i < PL; i++) p[8*(PL-1-i) +: 8] = 8'(i + 1) ^ psn[7:0];
    return p;
  endfunction

  function automatic int frame_bytes(input mod_t m);
    return (m == MOD_EXTRA) ? 178 : (m == MOD_TRUNC) ? 100 : 114;
  endfunction

  function automatic frame_t build_frame(input logic [23:0] qp, input logic [23:0] psn, input mod_t m);
    logic [7:0] fb [192];
    logic [19:0] s = '0;
    frame_t f = '0;
    for (int i = 0; i < 192; i++) fb[i] = (i >= 114) ? 8'hA5 : 8'h00;
    fb[6] = 8'h02; fb[11] = 8'h01;
    fb[12] = 8'h08; fb[13] = 8'h00;
    fb[14] = 8'h45; fb[17] = 8'd100; fb[19] = 8'h12; fb[20] = 8'h40;
    fb[22] = 8'h40; fb[23] = 8'h11;
    fb[26] = 8'h0A; fb[29] = 8'h01;
    fb[34] = 8'hC0; fb[36] = 8'h12; fb[37] = 8'hB7; fb[39] = 8'd80;
    fb[42] = 8'h04; fb[44] = 8'hFF; fb[45] = 8'hFF;
    fb[47] = qp[23:16];  fb[48] = qp[15:8];  fb[49] = qp[7:0];
    fb[51] = psn[23:16]; fb[52] = psn[15:8]; fb[53] = psn[7:0];
    for (int i = 0; i < PL; i++) fb[54+i] = 8'(i + 1) ^ psn[7:0];
    fb[110] = 8'hDE; fb[111] = 8'hAD; fb[112] = 8'hBE; fb[113] = 8'hEF;
    for (int k = 0; k < 10; k++) s += {4'd0, fb[14+2*k], fb[15+2*k]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    s = {4'd0, s[15:0]} + {19'd0, s[16]};
    fb[24] = ~s[15:8];
    fb[25] = ~s[7:0];
    case (m)
      MOD_CSUM:  fb[24] = fb[24] ^ 8'h01;
      MOD_ETYPE: begin fb[12] = 8'h86; fb[13] = 8'hDD; fb[24] = fb[24] ^ 8'h01; end
      MOD_UDP:   fb[37] = 8'hB8;
      MOD_BTH:   fb[42] = 8'h0A;
      default: ;
    endcase
    for (int i = 0; i < 192; i++) f[8*i +: 8] = fb[i];
    return f;
  endfunction

  task automatic drive_beat(input bit sel);
    int guard = 0;
    if (sel) tvalid_b = 1'b1; else tvalid_a = 1'b1;
    while (!(sel ? b_tready : a_tready) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("tready_wait", 1'(guard < 20), 1'b1);
    @(posedge clk); #1;
    tvalid_a = 1'b0;
    tvalid_b = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int nbytes, input bit sel);
    int nb = (nbytes + 63) / 64;
    for (int k = 0; k < nb; k++) begin
      int rem = nbytes - 64 * k;
      for (int j = 0; j < 64; j++) tkeep[j] = (j < rem);
      tdata = f[512*k +: 512];
      tlast = (k == nb - 1);
      drive_beat(sel);
      if (k != nb - 1)
        check("no_early_pulse", {a_rx_valid, a_rx_err_valid, b_rx_valid, b_rx_err_valid}, 4'b0);
    end
    tlast = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t vecs[12];
  logic [23:0] last_psn;

  initial begin
    vecs[0]  = '{1'b1, MOD_NONE,  24'h000011, 24'd0, 1'b1, 3'd0, 24'd1, 16'd1, 16'd0};
    vecs[1]  = '{1'b1, MOD_NONE,  24'h000123, 24'd0, 1'b1, 3'd0, 24'd1, 16'd1, 16'd0};
    vecs[2]  = '{1'b0, MOD_NONE,  24'h000123, 24'd1, 1'b1, 3'd0, 24'd2, 16'd2, 16'd0};
    vecs[3]  = '{1'b0, MOD_NONE,  24'h000123, 24'd2, 1'b1, 3'd0, 24'd3, 16'd3, 16'd0};
    vecs[4]  = '{1'b0, MOD_NONE,  24'h000123, 24'd2, 1'b0, 3'd6, 24'd3, 16'd3, 16'd1};
    vecs[5]  = '{1'b0, MOD_CSUM,  24'h000123, 24'd3, 1'b0, 3'd2, 24'd3, 16'd3, 16'd2};
    vecs[6]  = '{1'b0, MOD_ETYPE, 24'h000123, 24'd3, 1'b0, 3'd1, 24'd3, 16'd3, 16'd3};
    vecs[7]  = '{1'b0, MOD_UDP,   24'h000123, 24'd3, 1'b0, 3'd3, 24'd3, 16'd3, 16'd4};
    vecs[8]  = '{1'b0, MOD_BTH,   24'h000123, 24'd3, 1'b0, 3'd4, 24'd3, 16'd3, 16'd5};
    vecs[9]  = '{1'b0, MOD_EXTRA, 24'h000123, 24'd3, 1'b0, 3'd5, 24'd3, 16'd3, 16'd6};
    vecs[10] = '{1'b0, MOD_TRUNC, 24'h000123, 24'd3, 1'b0, 3'd5, 24'd3, 16'd3, 16'd7};
    vecs[11] = '{1'b0, MOD_NONE,  24'hABCDEF, 24'd3, 1'b1, 3'd0, 24'd4, 16'd4, 16'd7};

    rst = 1'b1; tdata = '0; tkeep = '0; tlast = 1'b0; tvalid_a = 1'b0; tvalid_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_tready",   a_tready, 1'b1);
    check("reset_pulses",   {a_rx_valid, a_rx_err_valid, a_rx_err_code}, 5'd0);
    check("reset_rx_data",  {a_rx_dest_qp, a_rx_psn, a_rx_payload}, '0);
    check("reset_exp_psn",  a_exp_psn, 24'd0);
    check("reset_counters", {a_ok_cnt, a_err_cnt}, 32'd0);
    check("reset_wrap_exp_psn", b_exp_psn, 24'hFFFFFF);

    // PSN wrap on the instance whose expected PSN starts at FFFFFF.
    send_frame(build_frame(24'h000022, 24'hFFFFFF, MOD_NONE), 114, 1'b1);
    check("wrap_rx_valid", b_rx_valid, 1'b1);
    check("wrap_rx_psn",   b_rx_psn, 24'hFFFFFF);
    check("wrap_exp_psn",  b_exp_psn, 24'd0);
    send_frame(build_frame(24'h000022, 24'd0, MOD_NONE), 114, 1'b1);
    check("wrap_next_valid", {b_rx_valid, b_rx_err_valid}, 2'b10);
    check("wrap_next_exp",   b_exp_psn, 24'd1);
    check("wrap_ok_cnt",     b_ok_cnt, 16'd2);

    last_psn = '0;
    foreach (vecs[v]) begin
      if (vecs[v].do_rst) begin
        pulse_reset();
        last_psn = '0;
      end
      send_frame(build_frame(vecs[v].qp, vecs[v].psn, vecs[v].m), frame_bytes(vecs[v].m), 1'b0);
      check($sformatf("v%0d_pulses", v), {a_rx_valid, a_rx_err_valid},
            vecs[v].exp_ok ? 2'b10 : 2'b01);
      check($sformatf("v%0d_exp_psn", v), a_exp_psn, vecs[v].exp_psn);
      check($sformatf("v%0d_ok_cnt", v),  a_ok_cnt,  vecs[v].exp_ok_cnt);
      check($sformatf("v%0d_err_cnt", v), a_err_cnt, vecs[v].exp_err_cnt);
      if (vecs[v].exp_ok) begin
        last_psn = vecs[v].psn;
        check($sformatf("v%0d_dest_qp", v), a_rx_dest_qp, vecs[v].qp);
        check($sformatf("v%0d_payload", v), a_rx_payload, exp_payload(vecs[v].psn));
      end else begin
        check($sformatf("v%0d_err_code", v), a_rx_err_code, vecs[v].exp_code);
      end
      check($sformatf("v%0d_rx_psn", v), a_rx_psn, last_psn);
      if (v == 0)
        check("v0_payload_msb", a_rx_payload[PL*8-1 -: 8], 8'h01);
    end

    // Reset while the second beat is presented: the partial frame vanishes.
    begin
      frame_t f = build_frame(24'h000033, 24'd0, MOD_NONE);
      tdata = f[511:0];
      tkeep = '1;
      tlast = 1'b0;
      drive_beat(1'b0);
      tdata = f[1023:512];
      for (int j = 0; j < 64; j++) tkeep[j] = (j < 50);
      tlast = 1'b1;
      tvalid_a = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tvalid_a = 1'b0;
      tlast = 1'b0;
      check("midrst_pulses",   {a_rx_valid, a_rx_err_valid}, 2'b00);
      check("midrst_counters", {a_ok_cnt, a_err_cnt}, 32'd0);
      check("midrst_exp_psn",  a_exp_psn, 24'd0);
      @(posedge clk); #1;
      check("midrst_quiet", {a_rx_valid, a_rx_err_valid, a_tready}, 3'b001);
      send_frame(f, 114, 1'b0);
      check("midrst_good_pulses", {a_rx_valid, a_rx_err_valid}, 2'b10);
      check("midrst_good_qp",     a_rx_dest_qp, 24'h000033);
      check("midrst_good_ok_cnt", a_ok_cnt, 16'd1);
      check("midrst_good_exp",    a_exp_psn, 24'd1);
    end

    @(posedge clk); #1;
    check("done_bubble_end", {a_rx_valid, a_rx_err_valid, a_tready}, 3'b001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
